fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Program-counter and next-PC stage of the single-cycle MIPS core; sits directly upstream of IM.
//   Drives IM_Address every cycle from the registered PC, selects the next PC (sequential /
//   beq-bne / j-jal / jr) from decoder controls, and supplies the jal link value.
//   Adds stall hold, a retired-instruction counter, and self-loop halt detection for benches.
// PARAMETERS
//   mem_size   16  width of PC / IM_Address (word index, not byte address)
//   RESET_PC   0   PC value loaded on reset
//   HALT_CNT   4   consecutive self-loop cycles before entering HALT (>=1)
//   CNT_W      32  width of retired-instruction counter
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         asynchronous reset, active-high
//   stall        in   1         hold PC this cycle; no retire
//   branch_taken in   1         beq/bne resolved taken
//   branch_imm   in   16        signed word offset (Instruction[15:0])
//   jump         in   1         j or jal
//   jump_target  in   26        Instruction[25:0]
//   jr           in   1         jump register
//   jr_target    in   32        rs value (word index)
//   IM_Address   out  mem_size  current PC, to IM
//   link_addr    out  mem_size  PC+1, written to $ra by jal
//   retired      out  CNT_W     count of instructions retired since reset
//   halted       out  1         self-loop detected; PC frozen
// BEHAVIOUR
//   Reset (async, immediate, any state): PC=RESET_PC, retired=0, halted=0, loop_cnt=0, state RUN.
//   IM_Address = PC register, zero-latency from register (no combinational input path).
//   link_addr = PC+1 mod 2^mem_size, combinational from PC.
//   next-PC priority (one-hot expected from decoder; priority enforced anyway):
//     jr > jump > branch_taken > sequential.
//     sequential: PC+1;  branch: PC+1+sext(branch_imm);  jump: jump_target[mem_size-1:0];
//     jr: jr_target[mem_size-1:0]. All arithmetic truncated to mem_size bits.
//   Wrap: PC=2^mem_size-1 sequential -> 0; branch targets wrap modulo 2^mem_size, no error.
//   FSM states RUN, HALT:
//     RUN, stall=1: PC, retired, loop_cnt unchanged.
//     RUN, stall=0: PC<=next-PC; retired<=retired+1 (saturates at all-ones);
//       if next-PC==PC then loop_cnt<=loop_cnt+1 else loop_cnt<=0;
//       when loop_cnt reaches HALT_CNT-1 on a self-loop cycle -> HALT, halted<=1 same edge.
//     HALT: PC, retired frozen; all control inputs ignored; exit only via rst.
//   Control inputs sampled only at rising clk; one PC update per cycle (single-cycle core).
//   Simultaneous stall and redirect: stall wins, redirect is dropped (decoder re-asserts next cycle).
//   Reset asserted mid-cycle: outputs go to reset values without waiting for clk.
// STRUCTURE
//   Shared package (cpu_pkg): mem_size default, opcode constants (OP_BEQ, OP_BNE, OP_J, OP_JAL),
//     funct FN_JR, fetch FSM state encoding (ST_RUN, ST_HALT).
//   One sub-module: next_pc_sel (combinational priority mux + adders); FSM, PC, counters in top level.
// TESTING
//   1 Reset: rst pulse at t=6ns for one period -> IM_Address=0, retired=0, halted=0 before first edge.
//   2 Sequential: 31 unstalled cycles -> IM_Address=31, retired=31, link_addr=32.
//   3 Branch: PC=40, branch_taken=1, branch_imm=16'hFFFD -> next IM_Address=38; imm=3 -> 44.
//   4 Jump/jr priority: PC=44, jump=1 target=51, jr=1 jr_target=60 same cycle -> IM_Address=60;
//     jal alone at PC=44 -> IM_Address=51, link_addr=45 during the PC=44 cycle.
//   5 Stall + wrap: PC=16'hFFFF, stall=1 for 3 cycles -> PC, retired unchanged; release -> PC=0.
//   6 Halt: jump to self at PC=60 for HALT_CNT=4 cycles -> halted=1, retired frozen, later jr=1
//     ignored; async rst mid-cycle -> IM_Address=0, halted=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: address width default,
// opcode/funct constants seen by the decoder, and the fetch FSM encoding.
package cpu_pkg;

    localparam int MEM_SIZE = 16;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jr > jump > branch > sequential, plus the
// jal link value. All arithmetic wraps modulo 2^mem_size.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int mem_size = MEM_SIZE
) (
    input  logic [mem_size-1:0] pc,
    input  logic                branch_taken,
    input  logic [15:0]         branch_imm,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    input  logic                jr,
    input  logic [31:0]         jr_target,
    output logic [mem_size-1:0] next_pc,
    output logic [mem_size-1:0] link_addr
);

    logic [mem_size-1:0] pc_plus1;
    logic [mem_size-1:0] imm_ext;
    logic [mem_size-1:0] branch_pc;

    assign pc_plus1  = pc + mem_size'(1);
    // Size cast of a signed operand sign-extends when mem_size exceeds 16.
    assign imm_ext   = mem_size'(signed'(branch_imm));
    assign branch_pc = pc_plus1 + imm_ext;
    assign link_addr = pc_plus1;

    always_comb begin
        // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
        next_pc = pc_plus1;
        if (jr) begin
            next_pc = mem_size'(jr_target);
        end else if (jump) begin
            next_pc = mem_size'(jump_target);
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end
    end

endmodule : next_pc_sel

// File: rtl/fetch_unit.sv
// PC register and fetch FSM of the single-cycle core: stall hold, retired-instruction
// counter and self-loop halt detection. IM_Address comes straight from the PC register.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int mem_size = MEM_SIZE,
    parameter int RESET_PC = 0,
    parameter int HALT_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [15:0]         branch_imm,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    input  logic                jr,
    input  logic [31:0]         jr_target,
    output logic [mem_size-1:0] IM_Address,
    output logic [mem_size-1:0] link_addr,
    output logic [CNT_W-1:0]    retired,
    output logic                halted
);

    localparam int LOOP_W = $clog2(HALT_CNT + 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(HALT_CNT - 1);

    fetch_state_t        state;
    logic [mem_size-1:0] pc;
    logic [mem_size-1:0] next_pc;
    logic [LOOP_W-1:0]   loop_cnt;
    logic                self_loop;

    next_pc_sel #(
        .mem_size (mem_size)
    ) u_next_pc_sel (
        .pc           (pc),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .next_pc      (next_pc),
        .link_addr    (link_addr)
    );

    assign IM_Address = pc;
    assign self_loop  = (next_pc == pc);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            pc       <= mem_size'(RESET_PC);
            retired  <= '0;
            loop_cnt <= '0;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        pc <= next_pc;
                        if (retired != '1) begin
                            retired <= retired + CNT_W'(1);
                        end
                        if (self_loop) begin
                            loop_cnt <= loop_cnt + LOOP_W'(1);
                            if (loop_cnt == LOOP_LAST) begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end
                        end else begin
                            loop_cnt <= '0;
                        end
                    end
                end
                ST_HALT: begin
                    // Frozen until reset; all control inputs are ignored.
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule : fetch_unit
